// File: rtl/gerador_pulsos.sv
`default_nettype none
// gerador_pulsos: key synchronise/debounce, load pulse, run flag and tick prescaler.
// Rev 1.0

module gerador_pulsos #(
   parameter int DIV = 50000000,
   parameter int DEB = 500000
) (
   input  logic clock,
   input  logic reset,
   input  logic key_carga_n,
   input  logic key_pausa_n,
   output logic botao,
   output logic tick,
   output logic rodando
);

   localparam int CW = $clog2(DEB) + 1;
   localparam int PW = $clog2(DIV);
   localparam logic [CW-1:0] C_DEB_MAX = CW'(DEB - 1);
   localparam logic [PW-1:0] C_DIV_MAX = PW'(DIV - 1);

   // Bit 0 carries the load key, bit 1 the start/pause key.
   logic [1:0]    w_raw;
   logic [1:0]    r_s1;
   logic [1:0]    r_s2;
   logic [1:0]    r_d;
   logic [1:0]    r_d_q;
   logic [CW-1:0] r_cnt [2];
   logic [PW-1:0] r_p;
   logic          w_load;
   logic          w_pause;

   assign w_raw   = {key_pausa_n, key_carga_n};
   assign w_load  = r_d_q[0] & ~r_d[0];
   assign w_pause = r_d_q[1] & ~r_d[1];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_s1  <= '1;
         r_s2  <= '1;
         r_d   <= '1;
         r_d_q <= '1;
         for (int k = 0; k < 2; k++) begin
            r_cnt[k] <= '0;
         end
      end else begin
         r_s1  <= w_raw;
         r_s2  <= r_s1;
         r_d_q <= r_d;
         for (int k = 0; k < 2; k++) begin
            if (r_s2[k] == r_d[k]) begin
               r_cnt[k] <= '0;
            end else if (r_cnt[k] == C_DEB_MAX) begin
               r_d[k]   <= r_s2[k];
               r_cnt[k] <= '0;
            end else begin
               r_cnt[k] <= r_cnt[k] + CW'(1);
            end
         end
      end
   end

   // A load press restarts the period, so it overrides counting in the same cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         botao   <= 1'b0;
         tick    <= 1'b0;
         rodando <= 1'b0;
         r_p     <= '0;
      end else begin
         botao <= w_load;
         if (w_pause) begin
            rodando <= ~rodando;
         end
         if (w_load) begin
            r_p  <= '0;
            tick <= 1'b0;
         end else if (rodando) begin
            if (r_p == C_DIV_MAX) begin
               r_p  <= '0;
               tick <= 1'b1;
            end else begin
               r_p  <= r_p + PW'(1);
               tick <= 1'b0;
            end
         end else begin
            tick <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_gerador_pulsos.sv
`default_nettype none
// tb_gerador_pulsos: directed and random key stimulus against a history-based reference model.
// Rev 1.0

module tb_gerador_pulsos;

   localparam int DIV = 10;
   localparam int DEB = 4;

   logic clock;
   logic reset;
   logic key_carga_n;
   logic key_pausa_n;
   logic botao;
   logic tick;
   logic rodando;

   int checks;
   int failures;
   int cyc;

   gerador_pulsos #(.DIV(DIV), .DEB(DEB)) dut (
      .clock       (clock),
      .reset       (reset),
      .key_carga_n (key_carga_n),
      .key_pausa_n (key_pausa_n),
      .botao       (botao),
      .tick        (tick),
      .rodando     (rodando)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference model: full history of raw samples since reset; a level is accepted
   // once the synchronised key has disagreed with the debounced level for DEB
   // consecutive edges since the previous acceptance.
   logic [1:0] samp [$];
   bit         md    [2];
   bit         mfall [2];
   int         macc  [2];
   int         medge;
   bit         mrod;
   int         mrc;
   bit         mtick;
   bit         mbotao;

   function automatic bit s2_at(input int e, input int k);
      if (e < 3) return 1'b1;
      return samp[e-3][k];
   endfunction

   task automatic model_reset();
      samp.delete();
      for (int k = 0; k < 2; k++) begin
         md[k]    = 1'b1;
         mfall[k] = 1'b0;
         macc[k]  = 0;
      end
      medge  = 0;
      mrod   = 1'b0;
      mrc    = 0;
      mtick  = 1'b0;
      mbotao = 1'b0;
   endtask

   task automatic model_edge(input logic [1:0] raw);
      bit load;
      bit pz;
      bit ok;
      medge++;
      samp.push_back(raw);
      load = mfall[0];
      pz   = mfall[1];
      for (int k = 0; k < 2; k++) begin
         mfall[k] = 1'b0;
         if (medge - DEB + 1 > macc[k]) begin
            ok = 1'b1;
            for (int j = 0; j < DEB; j++) begin
               if (s2_at(medge - j, k) == md[k]) ok = 1'b0;
            end
            if (ok) begin
               mfall[k] = md[k];
               md[k]    = ~md[k];
               macc[k]  = medge;
            end
         end
      end
      mbotao = load;
      if (load) begin
         mrc   = 0;
         mtick = 1'b0;
      end else if (mrod) begin
         mrc   = mrc + 1;
         mtick = (mrc % DIV) == 0;
      end else begin
         mtick = 1'b0;
      end
      if (pz) mrod = ~mrod;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic compare_all();
      chk("botao", botao, mbotao);
      chk("tick", tick, mtick);
      chk("rodando", rodando, mrod);
      chk("botao_tick_excl", botao & tick, 0);
   endtask

   task automatic step(input bit kc, input bit kp);
      key_carga_n = kc;
      key_pausa_n = kp;
      @(posedge clock);
      if (reset) model_reset();
      else model_edge({kp, kc});
      cyc++;
      #1;
      compare_all();
   endtask

   int  pulses;
   int  nt;
   int  prev;
   int  first;
   int  found;
   bit  rod_before;
   bit  kc;
   bit  kp;

   initial begin
      checks      = 0;
      failures    = 0;
      cyc         = 0;
      reset       = 1'b1;
      key_carga_n = 1'b1;
      key_pausa_n = 1'b1;
      model_reset();
      repeat (3) @(posedge clock);
      #1;
      compare_all();
      reset = 1'b0;

      // Idle after reset: nothing may move.
      pulses = 0;
      repeat (100) begin
         step(1, 1);
         pulses += botao + tick + rodando;
      end
      chk("idle_quiet", pulses, 0);

      // Clean pause press: run flag rises at edge DEB+3.
      for (int e = 1; e <= 7; e++) begin
         step(1, 0);
         if (e == 6) chk("pause_edge6", rodando, 0);
         if (e == 7) chk("pause_edge7", rodando, 1);
      end
      prev = cyc;
      nt   = 0;
      for (int i = 0; i < 60 && nt < 5; i++) begin
         step(1, 1);
         if (tick) begin
            chk("tick_gap", cyc - prev, DIV);
            prev = cyc;
            nt++;
         end
      end
      chk("tick_count", nt, 5);

      // Bouncing load key, then held low.
      pulses = 0;
      for (int b = 0; b < 4; b++) begin
         step(b[0], 1);
         pulses += botao;
         step(b[0], 1);
         pulses += botao;
      end
      chk("bounce_no_pulse", pulses, 0);
      first  = 0;
      pulses = 0;
      for (int e = 1; e <= 15; e++) begin
         step(0, 1);
         if (botao) begin
            pulses++;
            if (first == 0) first = e;
         end
      end
      chk("load_edge", first, 7);
      chk("load_single", pulses, 1);
      pulses = 0;
      repeat (20) begin
         step(1, 1);
         pulses += botao;
      end
      chk("load_release_quiet", pulses, 0);

      // Load while running, timed so the prescaler holds 6 at the load edge.
      found = 0;
      for (int i = 0; i < 2 * DIV && found == 0; i++) begin
         if (mrc % DIV == 0) found = 1;
         else step(1, 1);
      end
      chk("wait_p0", found, 1);
      for (int e = 1; e <= 7; e++) begin
         step(0, 1);
         if (e == 7) begin
            chk("load_run_botao", botao, 1);
            chk("load_run_tick", tick, 0);
         end
      end
      prev  = cyc;
      found = 0;
      for (int i = 0; i < 2 * DIV && found == 0; i++) begin
         step(1, 1);
         if (tick) begin
            chk("tick_after_load", cyc - prev, DIV);
            found = 1;
         end
      end
      chk("tick_after_load_seen", found, 1);

      // Pause so that the prescaler is held at 3, wait, then resume.
      found = 0;
      for (int i = 0; i < 2 * DIV && found == 0; i++) begin
         if (mrc % DIV == 6) found = 1;
         else step(1, 1);
      end
      chk("wait_p6", found, 1);
      for (int e = 1; e <= 7; e++) begin
         step(1, 0);
         if (e == 7) chk("paused", rodando, 0);
      end
      pulses = 0;
      repeat (50) begin
         step(1, 1);
         pulses += tick;
      end
      chk("no_tick_paused", pulses, 0);
      for (int e = 1; e <= 7; e++) begin
         step(1, 0);
         if (e == 7) chk("resumed", rodando, 1);
      end
      prev  = cyc;
      found = 0;
      for (int i = 0; i < 2 * DIV && found == 0; i++) begin
         step(1, 1);
         if (tick) begin
            chk("tick_after_resume", cyc - prev, 7);
            found = 1;
         end
      end
      chk("tick_after_resume_seen", found, 1);

      // Both keys on the same edge.
      rod_before = rodando;
      for (int e = 1; e <= 7; e++) begin
         step(0, 0);
         if (e == 7) begin
            chk("both_botao", botao, 1);
            chk("both_rodando", rodando, !rod_before);
            chk("both_tick", tick, 0);
         end
      end
      repeat (20) step(1, 1);

      // Reset in the middle of a debounce.
      repeat (3) step(1, 0);
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      repeat (3) step(1, 1);
      reset  = 1'b0;
      pulses = 0;
      repeat (30) begin
         step(1, 1);
         pulses += botao + tick + rodando;
      end
      chk("after_reset_quiet", pulses, 0);

      // Random key activity with short bounces and longer holds.
      kc = 1'b1;
      kp = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 7) == 0) kc = ~kc;
         if ($urandom_range(0, 7) == 0) kp = ~kp;
         if ($urandom_range(0, 599) == 0) begin
            reset = 1'b1;
            model_reset();
            #1;
            compare_all();
            step(kc, kp);
            reset = 1'b0;
         end else begin
            step(kc, kp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gerador_pulsos.md
# gerador_pulsos

Front-end stage for the countdown timer. It synchronises and debounces the two board push-buttons and produces a one-cycle `botao` load pulse for the digit counters' preset path. It also divides the board clock into a one-cycle `tick` enable that advances the counters, gated by a start/pause run flag. All outputs are registered and intended to drive the counter chain directly.

## Interface
- `DIV`, 50000000: clock cycles per `tick` (1 Hz at 50 MHz); legal range ≥ 2.
- `DEB`, 500000: consecutive stable cycles required to accept a button level change (10 ms at 50 MHz); legal range ≥ 1.

- `clock`  in  1  single system clock, rising-edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `key_carga_n`  in  1  raw load button, active-low, asynchronous to `clock`.
- `key_pausa_n`  in  1  raw start/pause button, active-low, asynchronous to `clock`.
- `botao`  out  1  load pulse, high for exactly one cycle per accepted load press.
- `tick`  out  1  count enable, high for exactly one cycle every `DIV` running cycles.
- `rodando`  out  1  run flag; 1 = counting, 0 = paused.

## Operation
- Each key has its own 2-flop synchroniser (`s1` → `s2`), reset value 1 (released).
- Each key has its own debouncer:
  - Debounced state `d` resets to 1; counter `c` (width clog2(DEB)+1) resets to 0.
  - If `s2 == d`: `c <= 0`.
  - If `s2 != d` and `c == DEB-1`: `d <= s2`, `c <= 0`.
  - Otherwise: `c <= c+1`.
  - Any bounce back to `d` before acceptance restarts the count.
- Press detect: a registered pulse fires when `d` goes 1→0. Release (0→1) produces nothing.
- Load press: `botao <= 1` for one cycle. The same edge clears the prescaler to 0 and forces `tick` low. `rodando` is unchanged.
- Pause press: `rodando <= ~rodando`.
- Prescaler `p` (0..DIV-1):
  - Counts only while `rodando = 1`.
  - At `p == DIV-1`: `p <= 0` and `tick <= 1`. Otherwise `tick <= 0`.
  - While paused, `p` holds its value and `tick` stays 0. Resuming continues from the held value, so no partial period is lost or restarted.
- Load and pause accepted in the same cycle: both take effect. `botao` pulses, `p` clears, `rodando` toggles, `tick` is 0.
- Holding a key down indefinitely gives exactly one pulse, with no auto-repeat.

## Timing
- Reset values: `botao = 0`, `tick = 0`, `rodando = 0`, `p = 0`, both `d = 1`, both `c = 0`, synchronisers = 1. No pulse may appear after reset deassertion while the keys are released.
- Press latency: number edges from 1 at the first rising edge that samples the new raw level. For a clean edge:
  - `s2` changes at edge 2.
  - `d` changes at edge DEB+2.
  - `botao` (or the `rodando` toggle) is registered at edge DEB+3.
- Tick period: with `rodando` held at 1, consecutive `tick` pulses are exactly DIV cycles apart.
  - First tick after a load pulse: DIV cycles after the `botao` cycle.
  - First tick after a resume: DIV − (held `p`) cycles after `rodando` rises.
- `tick` and `botao` are never high in the same cycle.
- `reset` asserted mid-debounce or mid-period aborts immediately. No pulse is emitted on deassertion.

## Test plan
Use DIV=10, DEB=4 for all scenarios.
- Reset, keys released for 100 cycles → `botao`, `tick`, `rodando` all stay 0.
- Clean `key_pausa_n` 1→0 at edge 1 → `rodando` = 1 after edge 7. Then `tick` pulses every 10 cycles; count 5 pulses with exact spacing.
- `key_carga_n` bouncing 0,1,0,1 at 2-cycle intervals, then held low → no pulse during the bounce. Exactly one `botao` pulse 7 edges after the final stable low, and none on release.
- While running with `p` = 6, press load → `botao` pulses for 1 cycle, no `tick` in that cycle, next `tick` 10 cycles later.
- Pause at `p` = 3, wait 50 cycles, resume → no `tick` while paused; first `tick` 7 cycles after `rodando` rises.
- Press both keys on the same edge → single `botao` pulse and `rodando` toggles on the same edge. Then assert `reset` mid-debounce of a new press → all outputs return to 0 and no pulse after release of `reset`.
